// File: rtl/burst_line_adapter_if.sv
// Bundle of the cache-side DFP port and the banked-memory port of the burst adapter.
// slave is the adapter's view; master is the requester/memory environment's view.
interface burst_line_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BUS_W-1:0]  bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BUS_W-1:0]  bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/burst_line_adapter.sv
// Line-to-bus burst adapter: one request in flight, reads collect BEATS tagged beats,
// writes stream the latched line lowest word first under bmem_ready backpressure.
module burst_line_adapter #(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  burst_line_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BEAT, RESP} state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [ADDR_W-1:0]             addr_q;
  logic [BEATS-1:0][BUS_W-1:0]   wline_q;
  logic [BEATS-2:0][BUS_W-1:0]   rbuf_q;
  logic [LINE_W-1:0]             rline_q;
  logic                          last_beat, beat_hit, wr_acc;

  assign last_beat = (cnt == CNT_W'(BEATS-1));
  assign beat_hit  = (state == RD_DATA) && bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
  assign wr_acc    = (state == WR_BEAT) && bus.bmem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.dfp_read)            state_nxt = RD_CMD;
               else if (bus.dfp_write)      state_nxt = WR_BEAT;
      RD_CMD:  if (bus.bmem_ready)          state_nxt = RD_DATA;
      RD_DATA: if (beat_hit && last_beat)   state_nxt = RESP;
      WR_BEAT: if (wr_acc && last_beat)     state_nxt = RESP;
      RESP:                                 state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Beats land in a staging buffer; the visible line only updates when the last
  // beat arrives, so dfp_rdata keeps the previous line during a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      rline_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dfp_read) begin
            addr_q <= bus.dfp_addr;
          end else if (bus.dfp_write) begin
            addr_q  <= bus.dfp_addr;
            wline_q <= bus.dfp_wdata;
            cnt     <= '0;
          end
        end
        RD_CMD: if (bus.bmem_ready) cnt <= '0;
        RD_DATA: begin
          if (beat_hit) begin
            for (int b = 0; b < BEATS-1; b++)
              if (cnt == CNT_W'(b)) rbuf_q[b] <= bus.bmem_rdata;
            if (last_beat) begin
              rline_q <= {bus.bmem_rdata, rbuf_q};
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WR_BEAT: if (wr_acc) cnt <= last_beat ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.bmem_read  = (state == RD_CMD);
  assign bus.bmem_write = (state == WR_BEAT);
  assign bus.bmem_addr  = (state == RD_CMD || state == WR_BEAT) ? addr_q : '0;
  assign bus.bmem_wdata = (state == WR_BEAT) ? wline_q[cnt] : '0;
  assign bus.dfp_resp   = (state == RESP);
  assign bus.dfp_rdata  = rline_q;
endmodule

// File: doc/burst_line_adapter.md
Name: burst_line_adapter

Overview:
- Parametrised line-to-bus burst adapter between the cache-side DFP port and the banked memory (bmem) port.
- Reads: issues one read command, collects BEATS = LINE_W/BUS_W data beats and returns the assembled line.
- Writes: latches the line and streams it as BEATS write beats, lowest word first, honouring bmem_ready backpressure.
- Explicit FSM with a single request in flight; replaces the earlier fixed-width, edge-guessing deserializer.

Parameters:
- LINE_W, 256, cache line width in bits; must be an integer multiple of BUS_W.
- BUS_W, 64, memory data bus width in bits; BEATS = LINE_W/BUS_W, with 2 <= BEATS <= 16.
- ADDR_W, 32, address width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dfp_addr  in  ADDR_W  line address; held stable by the requester until dfp_resp
- dfp_read  in  1  read request; held until dfp_resp
- dfp_write  in  1  write request; held until dfp_resp
- dfp_wdata  in  LINE_W  write line
- dfp_rdata  out  LINE_W  assembled read line
- dfp_resp  out  1  one-cycle completion pulse (read or write)
- bmem_addr  out  ADDR_W  command address
- bmem_read  out  1  read command strobe
- bmem_write  out  1  write beat strobe
- bmem_wdata  out  BUS_W  write beat data
- bmem_ready  in  1  memory accepts a command or write beat this cycle
- bmem_raddr  in  ADDR_W  address tag of the returning read beat
- bmem_rdata  in  BUS_W  read beat data
- bmem_rvalid  in  1  read beat valid; no backpressure on this path

Behaviour:
- Reset values:
  - State = IDLE; beat counter = 0.
  - dfp_resp = 0; dfp_rdata = 0.
  - bmem_read = 0; bmem_write = 0; bmem_wdata = 0; bmem_addr = 0.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_BEAT, RESP.
- IDLE:
  - dfp_read = 1 -> latch dfp_addr, go to RD_CMD.
  - Otherwise dfp_write = 1 -> latch dfp_addr and dfp_wdata, clear counter, go to WR_BEAT.
  - Read wins if both are asserted.
- RD_CMD:
  - bmem_read = 1 and bmem_addr = latched address, held until bmem_ready = 1.
  - Command is accepted on that cycle; go to RD_DATA with counter = 0.
- RD_DATA:
  - Each cycle with bmem_rvalid = 1 and bmem_raddr == latched address: write bmem_rdata into line bits [cnt*BUS_W +: BUS_W], then cnt++.
  - A valid beat with a mismatched raddr is dropped and cnt does not advance.
  - After beat BEATS-1 is captured, go to RESP.
- WR_BEAT:
  - bmem_write = 1; bmem_addr = latched address; bmem_wdata = latched line [cnt*BUS_W +: BUS_W].
  - cnt advances only on cycles where bmem_ready = 1; otherwise hold data and strobe.
  - When the last beat is accepted, go to RESP.
  - No idle cycles between beats when bmem_ready stays high.
- RESP:
  - dfp_resp = 1 for exactly one cycle; dfp_rdata holds the full line (unchanged for writes).
  - Next state is IDLE.
  - The requester drops its request this cycle; a request seen in IDLE on the following cycle is a new request.
- dfp_rdata is registered and holds its value until the next read completes.
- Latency (ready always high, rvalid back-to-back):
  - Read: request -> dfp_resp in 1 (IDLE) + 1 (RD_CMD) + memory latency + BEATS + 1 cycles.
  - Write: request -> dfp_resp in 1 + BEATS + 1 cycles.
- bmem_rvalid outside RD_DATA is ignored; nothing is written.
- Counter width is $clog2(BEATS); the last-beat compare is against BEATS-1, with no reliance on natural wrap-around.
- Reset mid-burst:
  - Any state returns to IDLE; strobes drop the next cycle.
  - Partially collected beats are discarded; no dfp_resp is issued for the aborted request.
- Requests that arrive while the FSM is not in IDLE are not sampled; the single in-flight request is the only one tracked.

Test Plan:
- Read, defaults:
  - Stimulus: dfp_read at addr 0x0000_1000; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... with raddr 0x1000.
  - Required: exactly one bmem_read pulse; dfp_rdata = {0x4444.., 0x3333.., 0x2222.., 0x1111..}; one dfp_resp pulse one cycle after beat 4.
- Write with backpressure:
  - Stimulus: dfp_write with line = {D3,D2,D1,D0}; bmem_ready low for 2 cycles before D1.
  - Required: bmem_wdata sequence D0,D1,D2,D3, each accepted once; D1 held for 3 cycles; exactly 4 accepted beats, then one dfp_resp.
- Simultaneous read and write at addr 0x2000:
  - Required: read serviced, write ignored until re-presented; no bmem_write during the read.
- Stray and mismatched beats:
  - Stimulus: rvalid in IDLE; one beat with raddr 0x3000 during a 0x2000 read.
  - Required: no state change; the mismatched beat is dropped; line assembly is correct from matching beats only.
- Reset after 2 of 4 write beats:
  - Required: bmem_write = 0 the next cycle; no dfp_resp.
  - A following read at 0x4000 completes normally.
- Parameter sweep LINE_W=512, BUS_W=64 (8 beats) and LINE_W=128, BUS_W=64 (2 beats):
  - Required: beat ordering and dfp_resp timing match the latency formula.
